// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / divide unit with HI/LO result registers.
// One shift-add or shift-subtract step per cycle, then a single sign-fix cycle.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] p_q;
  logic [31:0] m_q;
  logic        div_q;
  logic        neg_q;
  logic        rem_neg_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;

  logic        signed_op;
  logic        is_div;
  logic        div_zero;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_trial;
  logic [63:0] step_d;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign signed_op = ~op[0];
  assign is_div    = op[1];
  assign div_zero  = (b == 32'd0);
  assign a_mag     = (signed_op && a[31]) ? (~a + 32'd1) : a;
  assign b_mag     = (signed_op && b[31]) ? (~b + 32'd1) : b;

  // p_q holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide.
  assign mul_sum   = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, m_q} : 33'd0);
  assign div_trial = p_q[63:31] - {1'b0, m_q};
  assign step_d    = div_q ? (div_trial[32] ? {p_q[62:0], 1'b0}
                                            : {div_trial[31:0], p_q[30:0], 1'b1})
                           : {mul_sum, p_q[31:1]};

  assign prod_fix  = neg_q ? (~p_q + 64'd1) : p_q;
  assign quo_fix   = neg_q ? (~p_q[31:0] + 32'd1) : p_q[31:0];
  assign rem_fix   = rem_neg_q ? (~p_q[63:32] + 32'd1) : p_q[63:32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      p_q       <= 64'd0;
      m_q       <= 32'd0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                m_q       <= is_div ? b_mag : a_mag;
                p_q       <= {32'd0, is_div ? a_mag : b_mag};
                div_q     <= is_div;
                // Divide by zero keeps the raw all-ones quotient; the remainder
                // fix then restores the original dividend into HI.
                neg_q     <= signed_op && (a[31] ^ b[31]) && !(is_div && div_zero);
                rem_neg_q <= signed_op && a[31];
                cnt_q     <= 5'd0;
                busy_q    <= 1'b1;
                state_q   <= CALC;
              end
              3'b100: hi_q <= a;
              3'b101: lo_q <= a;
              default: ;
            endcase
          end
        end
        CALC: begin
          p_q   <= step_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= FIX;
        end
        FIX: begin
          if (div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset; reset=0 forces the reset state immediately.
REQ-003 SHALL have port start, input, 1 bit: one-cycle operation request, sampled on the rising edge.
REQ-004 SHALL have port op, input, 3 bits: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-op.
REQ-005 SHALL have port a, input, 32 bits: multiplicand, dividend, or MTHI/MTLO source.
REQ-006 SHALL have port b, input, 32 bits: multiplier or divisor.
REQ-007 SHALL have port busy, output, 1 bit: a multi-cycle operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking that hi/lo were just written by MULT/MULTU/DIV/DIVU.
REQ-009 SHALL have port hi, output, 32 bits: registered HI; product[63:32] or remainder.
REQ-010 SHALL have port lo, output, 32 bits: registered LO; product[31:0] or quotient.

Function
REQ-011 SHALL implement three states: IDLE, CALC and FIX.
REQ-012 IDLE SHALL accept start=1 with op 000-011 as follows:
- latch operand magnitudes and the result signs (signed ops: |a|, |b|; unsigned ops: raw values);
- clear the iteration counter;
- go to CALC.
REQ-013 CALC SHALL perform exactly one iteration per cycle for 32 cycles:
- multiply: radix-2 shift-add;
- divide: restoring shift-subtract.
After the 32nd iteration the block SHALL go to FIX.
REQ-014 FIX SHALL, in one cycle:
- apply the sign correction;
- write hi/lo;
- drive done=1 and busy=0;
- return to IDLE.
REQ-015 Latency SHALL be fixed. If the accepting edge is E0, hi/lo/done update at E33 and done is high for exactly the cycle after E33.
REQ-016 busy SHALL be 1 from after E0 through the cycle ending at E33, and 0 otherwise.
REQ-017 Signed multiply SHALL negate the 64-bit magnitude product when a[31]^b[31]=1; unsigned multiply SHALL give the full 64-bit product.
REQ-018 Signed divide sign rules:
- quotient is negative when a[31]^b[31]=1;
- remainder takes the sign of a;
- results truncate toward zero.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0, with no flag.
REQ-020 Divide by zero (b=0, signed or unsigned) SHALL give lo=0xFFFFFFFF and hi=a unmodified, with no sign correction and normal latency.
REQ-021 MTHI/MTLO with start=1 in IDLE SHALL write a into hi/lo at that edge, with no busy and no done.
REQ-022 start SHALL be ignored while busy=1 (CALC or FIX); operands are not re-sampled.
REQ-023 start in the same cycle that done=1 SHALL be accepted, since the block is in IDLE.
REQ-024 hi/lo SHALL hold their values at all times except FIX, MTHI/MTLO and reset.
REQ-025 Ops 110/111 SHALL cause no state change.

Reset
REQ-026 reset=0 SHALL asynchronously force:
- state IDLE, counter 0;
- busy=0, done=0;
- hi=0, lo=0.
REQ-027 reset asserted mid-CALC or in FIX SHALL abort the operation with no done pulse and hi/lo=0.
REQ-028 After reset is released, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-029 MULT a=0xFFFFFFFE (-2), b=3 -> at E33 hi=0xFFFFFFFF, lo=0xFFFFFFFA, done one cycle, busy high E0..E33.
REQ-030 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-032 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; a second start at E5 with different operands -> ignored, same result at E33.
REQ-033 MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 on consecutive edges -> hi=0x12345678, lo=0x9ABCDEF0, done never asserted.
REQ-034 reset=0 at E10 of a MULTU -> busy=0, hi=lo=0 immediately, no done; a new DIVU 100/7 started after release -> lo=14, hi=2 at E33.
